pipe_add_sub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's combinational 32-bit CLA adder.
- Operand width, lookahead group size and pipeline depth are all parameters.
- Adds add/subtract mode, ALU status flags and a valid/ready handshake with backpressure.
- Sits between the register-file read ports and the ALU result mux.

---
 rtl/pipe_add_pkg.sv | 19 +
 rtl/pipe_add_sub_cla_group.sv | 39 +++
 rtl/pipe_add_sub.sv | 147 ++++++++++++++
 tb/tb_pipe_add_sub.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: default geometry, stage payload layout and saturation limits for pipe_add_sub.
package pipe_add_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_GROUP  = 4;
    localparam int DEF_STAGES = 2;
    localparam int CHUNK      = DEF_WIDTH / DEF_STAGES;
    localparam int NGROUP     = CHUNK / DEF_GROUP;
    localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum_lo;
        logic [DEF_WIDTH-1:0] a_hi;
        logic [DEF_WIDTH-1:0] b_hi;
        logic                 carry;
        logic                 c_msb_in;
        logic                 sat;
    } payload_t;
endpackage

// File: rtl/pipe_add_sub_cla_group.sv
// cla_group: GROUP-bit carry-lookahead slice; also exposes the carry into its top bit for overflow.
module cla_group
    import pipe_add_pkg::*;
#(
    parameter int GROUP = DEF_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             c_top_in
);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             pp;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of generate terms gated by the propagate run above them.
    always_comb begin
        c  = '0;
        pp = 1'b1;
        for (int i = 0; i <= GROUP; i++) begin
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & pp);
                pp   = pp & p[j];
            end
            c[i] = c[i] | (cin & pp);
        end
    end

    assign s        = p ^ c[GROUP-1:0];
    assign cout     = c[GROUP];
    assign c_top_in = c[GROUP-1];
endmodule

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: STAGES-deep pipelined CLA adder/subtractor with ALU flags and valid/ready backpressure.
// Define PIPE_ADD_SAT_EN to add the sat input that clamps overflowing results.
module pipe_add_sub
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int GROUP  = DEF_GROUP,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef PIPE_ADD_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int CW = WIDTH / STAGES;
    localparam int NG = CW / GROUP;
    localparam int L  = STAGES - 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = ~SMAX;

    typedef struct packed {
        logic [WIDTH-1:0] sum_lo;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic             carry;
        logic             c_msb_in;
        logic             sat;
    } stage_t;

    if (WIDTH % (STAGES * GROUP) != 0) begin : g_bad_cfg
        $error("pipe_add_sub: WIDTH must be a multiple of STAGES*GROUP");
    end

    stage_t [STAGES-1:0] st_d;
    stage_t [STAGES-1:0] st_q;
    stage_t              last_d;
    logic   [STAGES-1:0] vld_q;
    logic   [STAGES:0]   vin;
    logic   [STAGES:0]   rdy;
    logic   [WIDTH-1:0]  sum_d;
    logic                sat_in;
    logic                ovf_d;
    logic                ovf_q;
    logic                zero_q;
    logic                neg_q;

`ifdef PIPE_ADD_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    assign vin = {vld_q, in_valid};

    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !vld_q[k] | rdy[k+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        stage_t        p;
        stage_t        d;
        logic [NG:0]   c;
        logic [NG-1:0] ct;
        logic [CW-1:0] s;
        if (k == 0) begin : g_first
            assign p = '{sum_lo: '0, a_hi: a, b_hi: b ^ {WIDTH{sub}}, carry: cin ^ sub,
                         c_msb_in: 1'b0, sat: sat_in};
        end else begin : g_next
            assign p = st_q[k-1];
        end
        assign c[0] = p.carry;
        for (genvar g = 0; g < NG; g++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_cla (
                .a        (p.a_hi[k*CW + g*GROUP +: GROUP]),
                .b        (p.b_hi[k*CW + g*GROUP +: GROUP]),
                .cin      (c[g]),
                .s        (s[g*GROUP +: GROUP]),
                .cout     (c[g+1]),
                .c_top_in (ct[g])
            );
        end
        always_comb begin
            d                     = p;
            d.sum_lo[k*CW +: CW]  = s;
            d.carry               = c[NG];
            d.c_msb_in            = ct[NG-1];
        end
        assign st_d[k] = d;
    end

    // Saturation direction follows the sign of a, which rides along untouched in a_hi.
    assign ovf_d = st_d[L].carry ^ st_d[L].c_msb_in;
`ifdef PIPE_ADD_SAT_EN
    assign sum_d = (st_d[L].sat && ovf_d) ? (st_d[L].a_hi[WIDTH-1] ? SMIN : SMAX) : st_d[L].sum_lo;
`else
    assign sum_d = st_d[L].sum_lo;
`endif

    always_comb begin
        last_d        = st_d[L];
        last_d.sum_lo = sum_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            st_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) vld_q[k] <= vin[k];
                if (rdy[k] && vin[k]) st_q[k] <= (k == L) ? last_d : st_d[k];
            end
            if (rdy[L] && vin[L]) begin
                ovf_q  <= ovf_d;
                zero_q <= ~|sum_d;
                neg_q  <= sum_d[WIDTH-1];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vin[STAGES];
    assign sum       = st_q[L].sum_lo;
    assign cout      = st_q[L].carry;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: directed scoreboard bench for pipe_add_sub plus an exhaustive cla_group sweep.
module tb_pipe_add_sub;
    import pipe_add_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;

    logic [3:0]  ca;
    logic [3:0]  cb;
    logic        cc;
    logic [3:0]  cs;
    logic        cco;
    logic        cct;

    int   checks = 0;
    int   failures = 0;
    int   n_sent = 0;
    int   n_out = 0;
    int   n_disc = 0;
    res_t q[$];
    res_t mon_got;
    res_t mon_exp;
    logic [31:0] hold_sum;

    always #5 clk = ~clk;

    pipe_add_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef PIPE_ADD_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    cla_group #(.GROUP(4)) u_cla (
        .a        (ca),
        .b        (cb),
        .cin      (cc),
        .s        (cs),
        .cout     (cco),
        .c_top_in (cct)
    );

    function automatic res_t model(input logic [31:0] ta, input logic [31:0] tb,
                                   input logic ts, input logic tc, input logic tsat);
        logic [31:0] bx;
        logic [32:0] f;
        res_t        r;
        bx     = tb ^ {32{ts}};
        f      = {1'b0, ta} + {1'b0, bx} + {32'd0, tc ^ ts};
        r.sum  = f[31:0];
        r.cout = f[32];
        r.ovf  = (ta[31] == bx[31]) && (f[31] != ta[31]);
`ifdef PIPE_ADD_SAT_EN
        if (tsat && r.ovf) r.sum = ta[31] ? SAT_MIN : SAT_MAX;
`else
        if (tsat && 1'b0) r.sum = 32'd0;
`endif
        r.zero = (r.sum == 32'd0);
        r.neg  = r.sum[31];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                        input logic ts, input logic tc, input logic tsat);
        int n = 0;
        a = ta; b = tb; sub = ts; cin = tc; sat = tsat; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", 64'(n < 50), 64'd1);
        q.push_back(model(ta, tb, ts, tc, tsat));
        n_sent++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_got = '{sum, cout, ovf, zero, neg};
            n_out++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_output got=%0h exp=none", mon_got);
            end else begin
                mon_exp = q.pop_front();
                assert (mon_got === mon_exp) else begin
                    failures++;
                    $error("FAIL result got=%0h exp=%0h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            logic [4:0] full;
            logic [3:0] low;
            {ca, cb, cc} = 9'(i);
            #1;
            full = {1'b0, ca} + {1'b0, cb} + {4'd0, cc};
            low  = {1'b0, ca[2:0]} + {1'b0, cb[2:0]} + {3'd0, cc};
            chk("cla_group", {58'd0, cs, cco, cct}, {58'd0, full[3:0], full[4], low[3]});
        end
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_regs", {sum, cout, ovf, zero, neg}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        send(32'h5, 32'h3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_stage0", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("t1_sum", 64'(sum), 64'h8);
        chk("t1_flags", {cout, ovf, zero}, 64'd0);
        @(posedge clk);
        #1;

        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b1);
        send(32'h3, 32'h3, 1'b1, 1'b0, 1'b0);
        send(32'h0, 32'h1, 1'b1, 1'b0, 1'b0);
        send(32'h9, 32'h4, 1'b1, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        send(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        send(32'h0000_FFFF, 32'h0, 1'b0, 1'b1, 1'b0);
        drain();

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                hold_sum = sum;
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_valid", 64'(out_valid), 64'd1);
                    chk("bp_sum_stable", 64'(sum), 64'(hold_sum));
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        send(32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("inflight", 64'(q.size()), 64'd2);
        n_disc += q.size();
        q.delete();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_lat0", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("post_rst_lat1", 64'(out_valid), 64'd1);
        chk("post_rst_sum", 64'(sum), 64'h0123_4567);
        @(posedge clk);
        #1;
        drain();

        chk("result_count", 64'(n_out), 64'(n_sent - n_disc));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
